// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: tracks the PC, issues single-outstanding word
// fetches over a req/ack handshake, buffers returned words with their PCs in
// a small FIFO and hands them to decode on a valid/ready interface. A redirect
// flushes the buffer and restarts fetching at the new target; a fetch already
// in flight when the redirect arrives is completed and its data thrown away.
module if_prefetch_unit #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [DATA_W-1:0] inst_data_o,
   output logic [ADDR_W-1:0] inst_pc_o
);

   localparam int unsigned    PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned    CNT_W   = PTR_W + 1;
   // Depth at one extra bit so "count + 1" can be compared without overflow.
   localparam logic [CNT_W:0] DEPTH_X = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_e;

   state_e            state_q;
   logic              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] pc_q;

   logic [DATA_W-1:0] dat_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] apc_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_q;
   logic [PTR_W-1:0]  wr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;

   logic              pop;
   logic              push;
   logic [CNT_W-1:0]  cnt_pop;
   logic [CNT_W:0]    cnt_x;
   logic              room_idle;
   logic              room_next;
   logic [ADDR_W-1:0] redir_pc;
   logic [ADDR_W-1:0] pc_inc;

   assign pop       = inst_valid_o & inst_ready_i;
   // Data returned in a DROP, or on the same edge as a redirect, is stale.
   assign push      = (state_q == S_FETCH) & mem_ack_i & ~redirect_valid_i;
   assign cnt_pop   = cnt_q - CNT_W'(pop);
   assign cnt_x     = {1'b0, cnt_pop};
   // A new request reserves a slot, so it may issue only if that slot exists
   // after this cycle's pop (and, for back-to-back, after this cycle's push).
   assign room_idle = cnt_x < DEPTH_X;
   assign room_next = (cnt_x + (CNT_W + 1)'(1)) < DEPTH_X;
   assign redir_pc  = {redirect_pc_i[ADDR_W-1:2], 2'b00};
   assign pc_inc    = pc_q + ADDR_W'(4);

   // Occupancy next state: a redirect empties the buffer outright.
   always_comb begin
      cnt_d = cnt_q;
      if (redirect_valid_i) cnt_d = '0;
      else                  cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
   end

   assign mem_req_o    = req_q;
   assign mem_addr_o   = addr_q;
   assign inst_valid_o = (cnt_q != '0);
   assign inst_data_o  = dat_q[rd_q];
   assign inst_pc_o    = apc_q[rd_q];

   // Prefetch buffer storage and pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            dat_q[i] <= '0;
            apc_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         if (redirect_valid_i) begin
            rd_q <= '0;
            wr_q <= '0;
         end else begin
            if (push) begin
               dat_q[wr_q] <= mem_rdata_i;
               apc_q[wr_q] <= addr_q;
               wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop) rd_q <= rd_q + PTR_W'(1);
         end
      end
   end

   // Fetch FSM with registered request/address. pc_q holds the next address
   // to fetch (or, in DROP, the redirect target waiting to be issued).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         pc_q    <= RESET_PC;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (redirect_valid_i) begin
                  pc_q    <= redir_pc;
                  addr_q  <= redir_pc;
                  req_q   <= 1'b1;
                  state_q <= S_FETCH;
               end else if (room_idle) begin
                  addr_q  <= pc_q;
                  req_q   <= 1'b1;
                  state_q <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (redirect_valid_i) begin
                  pc_q <= redir_pc;
                  // Request cannot be withdrawn: wait out the ack in DROP
                  // unless it is completing right now.
                  if (mem_ack_i) addr_q  <= redir_pc;
                  else           state_q <= S_DROP;
               end else if (mem_ack_i) begin
                  pc_q <= pc_inc;
                  if (room_next) begin
                     addr_q <= pc_inc;
                  end else begin
                     req_q   <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            S_DROP: begin
               if (redirect_valid_i) pc_q <= redir_pc;
               if (mem_ack_i) begin
                  addr_q  <= redirect_valid_i ? redir_pc : pc_q;
                  state_q <= S_FETCH;
               end
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Instruction-fetch front end that feeds the cpu decode stage with instruction words.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake. At most one request is outstanding at a time.
- Buffers returned words in a small FIFO together with their PCs, and presents them to decode on a valid/ready interface.
- On a branch/jump redirect, flushes stale fetches and restarts at the new PC.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction word width
FIFO_DEPTH, 4, prefetch buffer entries (power of two, >=2)
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_req  out  1  fetch request, held until acked
mem_addr  out  ADDR_W  word-aligned fetch address, stable while mem_req=1
mem_ack  in  1  one-cycle ack; mem_rdata valid in the same cycle
mem_rdata  in  DATA_W  fetched instruction
redirect_valid  in  1  one-cycle branch/jump taken pulse
redirect_pc  in  ADDR_W  new fetch target
inst_valid  out  1  FIFO head is valid
inst_ready  in  1  decode accepts head this cycle
inst_data  out  DATA_W  instruction at FIFO head
inst_pc  out  ADDR_W  PC of instruction at FIFO head

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (async assert, sync deassert externally) forces:
  - pc=RESET_PC; FIFO empty; state=IDLE.
  - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
- Reset asserted mid-request: mem_req drops immediately. Memory is required to abandon the transaction.
- FSM states: IDLE, FETCH, DROP.
  - IDLE -> FETCH when occupancy < FIFO_DEPTH and no redirect this cycle. Registered mem_req=1, mem_addr=pc.
  - FETCH, on an edge with mem_ack=1:
    - Push {mem_rdata, mem_addr} into the FIFO; pc <= pc+4.
    - If occupancy after the push and any pop is still < FIFO_DEPTH, stay in FETCH with mem_addr=pc+4 (back-to-back, 1 word/cycle with zero-wait memory).
    - Otherwise go to IDLE with mem_req=0.
  - FETCH, on an edge with redirect_valid=1 and mem_ack=0: go to DROP. mem_req stays high with the old address; handshake rules forbid withdrawing a request.
  - DROP, on mem_ack: discard data, no push. mem_req <= 1, mem_addr <= the latched redirect target, go to FETCH.
- Occupancy counts FIFO entries only. The outstanding request is reserved: a new request issues only if count+1 <= FIFO_DEPTH after the current pop.
- Redirect handling (any state):
  - FIFO flushed (count=0, inst_valid=0 next cycle).
  - pc <= {redirect_pc[ADDR_W-1:2],2'b00}; low bits are forced to zero, not flagged.
  - From IDLE: next cycle mem_req=1 at the new pc, state FETCH.
- Simultaneous events:
  - redirect + mem_ack same edge: returned data discarded; next request is at the redirect target, no DROP.
  - redirect + inst_ready same edge: flush wins; the pop has no extra effect.
  - Second redirect while in DROP: the latched target is replaced by the newer one.
  - push + pop same edge with FIFO full or empty: count unchanged (full) or the word passes through (empty).
- PC arithmetic: modulo 2^ADDR_W, so 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Latency:
  - First mem_req rises on the first clk edge after rst_n deasserts.
  - inst_valid rises on the edge after the mem_ack edge, so ack-to-decode latency is 1 cycle.
- inst_data/inst_pc are driven from the FIFO head register and are stable while inst_valid=1 && inst_ready=0.

Test Plan:
1. Reset release, zero-wait memory (mem_ack=mem_req), inst_ready=1 -> addresses 0,4,8,C on consecutive cycles; inst_valid from cycle 2; inst_pc sequence 0,4,8,C; one word per cycle.
2. inst_ready=0, zero-wait memory -> exactly 4 fetches (0..C). mem_req=0 once full. inst_pc held at 0. Releasing inst_ready for one cycle triggers exactly one new fetch at 10.
3. Memory with 3-cycle ack latency; redirect_pc=0x100 pulsed 1 cycle after a request to 0x8 -> mem_addr stays 0x8 until ack; that data never appears; next mem_addr=0x100; first inst_pc after redirect = 0x100.
4. redirect_valid and mem_ack on the same edge (redirect_pc=0x203) -> ack data dropped; FIFO empty next cycle; next mem_addr=0x200.
5. RESET_PC=32'hFFFF_FFF8, zero-wait memory -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
6. rst_n pulled low while mem_req=1 and FIFO holds 2 entries -> mem_req and inst_valid drop asynchronously before the next edge. After release, fetch restarts at RESET_PC.
